// File: rtl/alu_writeback_buffer.sv
// Two-entry in-order buffer between the arithmetic unit and the register-file write port.
// Define ALU_WB_FLAGS_EN to build Z/N/C flag computation, per-entry flag storage and the flags register.
module alu_writeback_buffer #(
  parameter int WORD_SIZE     = 19,
  parameter int OPCODE_SIZE   = 5,
  parameter int REG_ADDR_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_SIZE-1:0]   in_opcode,
  input  logic [WORD_SIZE-1:0]     in_operand_1,
  input  logic [WORD_SIZE-1:0]     in_operand_2,
  input  logic [WORD_SIZE-1:0]     in_result,
  input  logic [REG_ADDR_SIZE-1:0] in_dest,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [REG_ADDR_SIZE-1:0] wr_addr,
  output logic [WORD_SIZE-1:0]     wr_data,
  output logic                     flag_zero,
  output logic                     flag_neg,
  output logic                     flag_carry,
  output logic [1:0]               count
);

  localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_MUL = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_DIV = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_INC = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_DEC = OPCODE_SIZE'(5);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic                     wr_ptr;
  logic                     rd_ptr;
  logic                     push;
  logic                     pop;
  logic [WORD_SIZE-1:0]     result_q [2];
  logic [REG_ADDR_SIZE-1:0] dest_q   [2];

  assign in_ready = !rst && (state != FULL);
  assign wr_en    = (state != EMPTY);
  assign push     = in_valid && in_ready;
  assign pop      = wr_en && wr_ready;
  assign count    = state;
  assign wr_addr  = dest_q[rd_ptr];
  assign wr_data  = result_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = FULL;
        else if (pop && !push) next_state = EMPTY;
      end
      FULL:    if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= '0;
        dest_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        result_q[wr_ptr] <= in_result;
        dest_q[wr_ptr]   <= in_dest;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef ALU_WB_FLAGS_EN
  // Entry flag bits packed as {upd, z, n, c}.
  logic [3:0] flags_q [2];
  logic [3:0] head_flags;
  logic       carry_next;
  logic       upd_next;
  logic       add_carry;

  // op1 + op2 overflows exactly when op1 exceeds the headroom left by op2.
  assign add_carry  = (in_operand_1 > ~in_operand_2);
  assign head_flags = flags_q[rd_ptr];

  always_comb begin
    carry_next = 1'b0;
    upd_next   = 1'b0;
    case (in_opcode)
      OP_ADD: begin carry_next = add_carry;                   upd_next = 1'b1; end
      OP_SUB: begin carry_next = (in_operand_1 < in_operand_2); upd_next = 1'b1; end
      OP_INC: begin carry_next = (in_operand_1 == '1);        upd_next = 1'b1; end
      OP_DEC: begin carry_next = (in_operand_1 == '0);        upd_next = 1'b1; end
      OP_MUL,
      OP_DIV:  upd_next = 1'b1;
      default: upd_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q[0] <= '0;
      flags_q[1] <= '0;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      if (push) begin
        flags_q[wr_ptr] <= {upd_next, (in_result == '0), in_result[WORD_SIZE-1], carry_next};
      end
      if (pop && head_flags[3]) begin
        flag_zero  <= head_flags[2];
        flag_neg   <= head_flags[1];
        flag_carry <= head_flags[0];
      end
    end
  end
`else
  logic unused_flag_inputs;

  assign unused_flag_inputs = ^{in_opcode, in_operand_1, in_operand_2};
  assign flag_zero  = 1'b0;
  assign flag_neg   = 1'b0;
  assign flag_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Scoreboard bench for alu_writeback_buffer: directed pushes queue hand-computed expected
// writes, and a negedge monitor checks every accepted write and the flags it commits.
module tb_alu_writeback_buffer;

  localparam int W = 19;
  localparam int OW = 5;
  localparam int AW = 4;

  localparam logic [OW-1:0] OP_ADD = 5'd0;
  localparam logic [OW-1:0] OP_SUB = 5'd1;
  localparam logic [OW-1:0] OP_MUL = 5'd2;
  localparam logic [OW-1:0] OP_DIV = 5'd3;
  localparam logic [OW-1:0] OP_INC = 5'd4;
  localparam logic [OW-1:0] OP_DEC = 5'd5;
  localparam logic [OW-1:0] OP_AND = 5'd6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          z;
    logic          n;
    logic          c;
    logic          upd;
  } entry_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_opcode;
  logic [W-1:0]  in_operand_1;
  logic [W-1:0]  in_operand_2;
  logic [W-1:0]  in_result;
  logic [AW-1:0] in_dest;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          flag_zero;
  logic          flag_neg;
  logic          flag_carry;
  logic [1:0]    count;

  int checks = 0;
  int errors = 0;
  entry_t sb[$];
  logic [2:0] model_flags = 3'b000;
  logic       flag_pending = 1'b0;

  alu_writeback_buffer #(.WORD_SIZE(W), .OPCODE_SIZE(OW), .REG_ADDR_SIZE(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_operand_1(in_operand_1), .in_operand_2(in_operand_2),
    .in_result(in_result), .in_dest(in_dest),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_carry(flag_carry),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one result, waits (bounded) for acceptance and queues the expected write.
  task automatic applyStimulus(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic [AW-1:0] dest,
                               input logic z, input logic n, input logic c, input logic upd);
    int waited;
    entry_t e;
    waited = 0;
`ifndef ALU_WB_FLAGS_EN
    z = 1'b0;
    n = 1'b0;
    c = 1'b0;
`endif
    in_valid = 1'b1;
    in_opcode = op;
    in_operand_1 = a;
    in_operand_2 = b;
    in_result = res;
    in_dest = dest;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    e.addr = dest;
    e.data = res;
    e.z = z;
    e.n = n;
    e.c = c;
    e.upd = upd;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: checks flags committed by the previous pop, then any write happening this cycle.
  always @(negedge clk) begin
    entry_t e;
    if (rst) begin
      model_flags = 3'b000;
      flag_pending = 1'b0;
    end else begin
      if (flag_pending) begin
        checkOutput("commit_flags", {29'd0, flag_zero, flag_neg, flag_carry}, {29'd0, model_flags});
        flag_pending = 1'b0;
      end
      if (wr_en && wr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_write: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(wr_data), 32'(e.data));
          if (e.upd) model_flags = {e.z, e.n, e.c};
          flag_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_opcode = '0;
    in_operand_1 = '0;
    in_operand_2 = '0;
    in_result = '0;
    in_dest = '0;
    wr_ready = 1'b1;
    tick();
    tick();

    // Reset state
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_wr_en", 32'(wr_en), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 0);
    checkOutput("rst_wr_data", 32'(wr_data), 0);
    checkOutput("rst_flags", {29'd0, flag_zero, flag_neg, flag_carry}, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);

    // Single ADD, one-cycle latency to wr_en
    applyStimulus(OP_ADD, 19'd10, 19'd5, 19'd15, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("lat_wr_en", 32'(wr_en), 1);
    checkOutput("lat_wr_addr", 32'(wr_addr), 3);
    checkOutput("lat_wr_data", 32'(wr_data), 15);
    tick();
    checkOutput("add_count_drain", 32'(count), 0);

    // Backpressure: fill, reject a third, then drain in order
    wr_ready = 1'b0;
    applyStimulus(OP_SUB, 19'd10, 19'd5, 19'd5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_DEC, 19'd10, 19'd0, 19'd9, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("full_count", 32'(count), 2);
    checkOutput("full_in_ready", 32'(in_ready), 0);
    checkOutput("stall_wr_addr", 32'(wr_addr), 1);
    checkOutput("stall_wr_data", 32'(wr_data), 5);
    in_valid = 1'b1;
    in_opcode = OP_ADD;
    in_result = 19'd99;
    in_dest = 4'd7;
    tick();
    in_valid = 1'b0;
    checkOutput("reject_count", 32'(count), 2);
    checkOutput("stable_wr_data", 32'(wr_data), 5);
    wr_ready = 1'b1;
    tick();
    checkOutput("drain1_count", 32'(count), 1);
    checkOutput("drain1_wr_addr", 32'(wr_addr), 2);
    tick();
    checkOutput("drain2_count", 32'(count), 0);
    checkOutput("drain2_in_ready", 32'(in_ready), 1);

    // Flag vectors, back to back with wr_ready held high
    applyStimulus(OP_INC, 19'h7FFFF, 19'd0, 19'd0, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(OP_MUL, 19'd3, 19'd4, 19'd12, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stream_count", 32'(count), 1);
    applyStimulus(OP_DIV, 19'd8, 19'd2, 19'd4, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 19'h7FFFF, 19'd1, 19'd0, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(OP_SUB, 19'd5, 19'd10, 19'h7FFFB, 4'd14, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(OP_AND, 19'd3, 19'd5, 19'd1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
`ifdef ALU_WB_FLAGS_EN
    checkOutput("flags_hold_after_and", {29'd0, flag_zero, flag_neg, flag_carry}, 32'b011);
`else
    checkOutput("flags_tied_off", {29'd0, flag_zero, flag_neg, flag_carry}, 32'b000);
`endif

    // Push and pop in the same cycle while holding one entry
    wr_ready = 1'b0;
    applyStimulus(OP_ADD, 19'd60, 19'd40, 19'd100, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    wr_ready = 1'b1;
    applyStimulus(OP_MUL, 19'd10, 19'd20, 19'd200, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pushpop_count1", 32'(count), 1);
    checkOutput("pushpop_wr_data1", 32'(wr_data), 200);
    applyStimulus(OP_SUB, 19'd5, 19'd10, 19'h7FFFB, 4'd7, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("pushpop_count2", 32'(count), 1);
    checkOutput("pushpop_wr_addr2", 32'(wr_addr), 7);
    tick();
    checkOutput("pushpop_drain", 32'(count), 0);
    tick();

    // Reset while full: entries discarded, reset-cycle push ignored
    wr_ready = 1'b0;
    applyStimulus(OP_ADD, 19'd5, 19'd6, 19'd11, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 19'd10, 19'd12, 19'd22, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("prerst_count", 32'(count), 2);
    rst = 1'b1;
    sb.delete();
    in_valid = 1'b1;
    in_opcode = OP_ADD;
    in_result = 19'd77;
    in_dest = 4'd15;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_count", 32'(count), 0);
    checkOutput("midrst_wr_en", 32'(wr_en), 0);
    checkOutput("midrst_flags", {29'd0, flag_zero, flag_neg, flag_carry}, 0);
    checkOutput("midrst_in_ready", 32'(in_ready), 1);
    wr_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("sb_empty_at_end", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
